demux_buf: RTL and testbench
============================

# demux_buf

Registered 1:M demultiplexer with valid/ready handshakes: one input stream carries a data word and a destination select, and each word is delivered to one of M independent output channels. Each channel has its own one-entry holding register, so channels drain independently. The block is the fan-out counterpart of the datapath select muxes. It sits between the debug unit / writeback source and the consumers that accept words at their own pace (display latch, memory-write staging, register-write staging).

## Interface
- N, default 32: data width in bits.
- M, default 4: number of output channels; power of two, M >= 2.
- S, default $clog2(M): select width; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block accepts the input word this cycle.
- in_data  input  N  input word.
- in_sel  input  S  destination channel index.
- out_valid  output  M  bit k set means channel k holds a word.
- out_ready  input  M  bit k set means the consumer of channel k takes its word this cycle.
- out_data  output  M*N  channel k's word on bits [k*N +: N].
- busy  output  1  OR of out_valid.

## Operation
- Transfers: input accepted when in_valid && in_ready. Channel k drains when out_valid[k] && out_ready[k].
- in_ready = !out_valid[in_sel] || out_ready[in_sel].
  - Combinational. Depends only on the selected channel. Never depends on in_valid.
- Accept into channel k (k = in_sel):
  - out_data[k] <= in_data; out_valid[k] <= 1.
  - Applies whether channel k was empty or draining in the same cycle (pass-through refill, no bubble).
- Drain only, no accept into that channel: out_valid[k] <= 0. out_data[k] holds its last value.
- Non-selected channels are unaffected by the input side, whatever the state of in_valid or in_data.
- Stall: out_valid[k] && !out_ready[k].
  - out_data[k] is held stable. out_valid[k] stays 1.
  - An input targeting k is back-pressured (in_ready = 0). Inputs targeting other channels still proceed.
- Ordering: words to the same channel are delivered in acceptance order. No ordering is defined across channels.
- No state machine beyond the M per-channel full bits. Each channel is either EMPTY or FULL:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or on stall.

## Timing
- Reset (async assert, released synchronously by the clock domain):
  - out_valid = 0, out_data = 0, busy = 0.
  - in_ready = 1 while in reset, because all channels read EMPTY.
- Latency: a word accepted at edge t is visible on out_valid/out_data immediately after edge t. It is consumable in the cycle following acceptance (1 cycle).
- Throughput per channel: 1 word/cycle when out_ready is held high.
- in_sel change while in_valid is high and in_ready is low is legal. in_ready re-evaluates against the new channel the same cycle.
- Reset mid-transfer: all held words are discarded. No output toggles after rst deasserts until the next accept.
- Drain and accept on the same channel in the same cycle: the new word replaces the old one at the edge. Exactly one delivery per accepted word, with no loss or duplication.
- Simultaneous drains on several channels are independent.

## Structure
- Shared header cpu_defs.vh holds the default DATA_W (32) and DBU channel index constants: CH_DISP=0, CH_MEM=1, CH_REG=2, CH_SPARE=3.
- Sub-module demux_slot (parameter N): one-entry holding register with in_valid/in_ready/out_valid/out_ready, clk, rst.
- demux_buf instantiates M demux_slot instances with a generate loop. It decodes in_sel into a one-hot slot write-enable and muxes the slot ready back out to in_ready.

## Test plan
- Reset: assert rst mid-run with channel 2 FULL -> out_valid=0, out_data=0, busy=0, in_ready=1. After release, no out_valid until the next accept.
- Basic route: in_sel=1, in_data=32'hDEADBEEF, out_ready=0 -> next cycle out_valid=4'b0010 and bits [63:32]=DEADBEEF. The next word with in_sel=1 sees in_ready=0.
- Independent back-pressure: channel 1 stalled, then send 32'h11 with in_sel=3 -> accepted. out_valid=4'b1010. Channel 1 data stays DEADBEEF.
- Pass-through refill: channel 0 FULL holding 32'hA, out_ready[0]=1, send 32'hB to sel 0 -> in_ready=1. Consumer sees A then B on consecutive cycles.
- Streaming: 16 words 0..15 to sel 2 with out_ready[2] held high -> 16 consecutive cycles of out_valid[2]=1 in order 0..15, with in_ready constantly 1.
- Random: random in_valid/in_sel/out_ready for 10k cycles against a per-channel FIFO model -> no loss, no duplication, per-channel order preserved, and busy == |out_valid at every cycle.

Source files
------------

// File: rtl/demux_buf_pkg.sv
// rtl/demux_buf_pkg.sv - shared widths, channel indices and slot state type for demux_buf
package demux_buf_pkg;

  // Default data width and channel count of the debug-unit fan-out.
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;

  // Debug-unit destination channel indices.
  typedef enum logic [1:0] {
    CH_DISP  = 2'd0,
    CH_MEM   = 2'd1,
    CH_REG   = 2'd2,
    CH_SPARE = 2'd3
  } dbu_ch_e;

  // A holding slot is either empty or holds exactly one word.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_buf_if.sv
// rtl/demux_buf_if.sv - input stream and per-channel output bundle of demux_buf
interface demux_buf_if
  import demux_buf_pkg::*;
#(
  parameter int N = DATA_W,
  parameter int M = NUM_CH
) ();
  localparam int S = $clog2(M);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic [S-1:0]   in_sel;
  logic [M-1:0]   out_valid;
  logic [M-1:0]   out_ready;
  logic [M*N-1:0] out_data;
  logic           busy;

  // The demux itself sits on the slave side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  // Producer plus consumers drive the master side.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry holding register with valid/ready on both sides
module demux_slot
  import demux_buf_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] out_data_o
);

  slot_state_e  state_q, state_d;
  logic [N-1:0] data_q, data_d;

  // Room exists when empty, or when the held word leaves this same cycle.
  assign in_ready_o  = (state_q == SLOT_EMPTY) || out_ready_i;
  assign out_valid_o = (state_q == SLOT_FULL);
  assign out_data_o  = data_q;

  // Accept wins over drain so a refill during drain leaves no bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (in_valid_i && in_ready_o) begin
      state_d = SLOT_FULL;
      data_d  = in_data_i;
    end else if ((state_q == SLOT_FULL) && out_ready_i) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot state and held word; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux_buf.sv
// rtl/demux_buf.sv - registered 1:M demultiplexer with one holding slot per channel
module demux_buf
  import demux_buf_pkg::*;
#(
  parameter int N = DATA_W,
  parameter int M = NUM_CH
) (
  input  logic      clk,
  input  logic      rst,
  demux_buf_if.slave bus
);
  localparam int S = $clog2(M);

  logic [M-1:0]   slot_we;
  logic [M-1:0]   slot_rdy;
  logic [M-1:0]   slot_vld;
  logic [M*N-1:0] slot_data;

  // Only the selected slot can back-pressure the input.
  assign bus.in_ready  = slot_rdy[bus.in_sel];
  assign bus.out_valid = slot_vld;
  assign bus.out_data  = slot_data;
  assign bus.busy      = |slot_vld;

  for (genvar k = 0; k < M; k++) begin : g_slot
    // One-hot write enable: non-selected slots never see the input.
    assign slot_we[k] = bus.in_valid && (bus.in_sel == S'(k));

    demux_slot #(.N(N)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (slot_we[k]),
      .in_ready_o  (slot_rdy[k]),
      .in_data_i   (bus.in_data),
      .out_valid_o (slot_vld[k]),
      .out_ready_i (bus.out_ready[k]),
      .out_data_o  (slot_data[k*N +: N])
    );
  end

endmodule

// File: tb/tb_demux_buf.sv
// tb/tb_demux_buf.sv - scoreboard bench for demux_buf
module tb_demux_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] exp_q [4][$];

  always #5 clk = ~clk;

  demux_buf_if #(.N(32), .M(4)) bus ();

  demux_buf #(.N(32), .M(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // One cycle: check against the model, update the model, advance to next negedge.
  task automatic step(input string tag);
    logic [3:0] mv;
    logic       exp_rdy;
    #1;
    for (int k = 0; k < 4; k++) mv[k] = (exp_q[k].size() != 0);
    total++;
    if (bus.out_valid !== mv) begin
      bad++;
      $display("FAIL %s out_valid got=%b exp=%b t=%0t", tag, bus.out_valid, mv, $time);
    end
    total++;
    if (bus.busy !== (|mv)) begin
      bad++;
      $display("FAIL %s busy got=%b exp=%b t=%0t", tag, bus.busy, |mv, $time);
    end
    exp_rdy = !mv[bus.in_sel] || bus.out_ready[bus.in_sel];
    total++;
    if (bus.in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL %s in_ready got=%b exp=%b t=%0t", tag, bus.in_ready, exp_rdy, $time);
    end
    for (int k = 0; k < 4; k++) begin
      if (mv[k]) begin
        total++;
        if (bus.out_data[k*32 +: 32] !== exp_q[k][0]) begin
          bad++;
          $display("FAIL %s ch%0d data got=%h exp=%h t=%0t", tag, k,
                   bus.out_data[k*32 +: 32], exp_q[k][0], $time);
        end
      end
    end
    for (int k = 0; k < 4; k++)
      if (mv[k] && bus.out_ready[k]) void'(exp_q[k].pop_front());
    if (bus.in_valid && exp_rdy) exp_q[bus.in_sel].push_back(bus.in_data);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r);
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic drain_all(input string tag);
    drive(1'b0, 2'd0, 32'h0, 4'hF);
    step(tag);
    step(tag);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (exp_q[k].size() != 0) begin
        bad++;
        $display("FAIL %s ch%0d leftover got=%0d exp=0", tag, k, exp_q[k].size());
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if (bus.out_valid !== 4'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s valid/busy got=%b/%b exp=0000/0", tag, bus.out_valid, bus.busy);
    end
    total++;
    if (bus.out_data !== 128'h0) begin
      bad++;
      $display("FAIL %s out_data got=%h exp=0", tag, bus.out_data);
    end
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready got=%b exp=1", tag, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 2'd2, 32'h1234, 4'h0);
    #2;
    check_reset_outputs("reset_init");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 4'h0);
    step("reset_idle");
    step("reset_idle");
  endtask

  task automatic test_basic_route();
    drive(1'b1, 2'd1, 32'hDEADBEEF, 4'h0);
    step("route_send");
    total++;
    if (bus.out_valid !== 4'b0010 || bus.out_data[63:32] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL route valid/data got=%b/%h exp=0010/deadbeef",
               bus.out_valid, bus.out_data[63:32]);
    end
    drive(1'b1, 2'd1, 32'h55, 4'h0);
    #1;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL route_block in_ready got=%b exp=0", bus.in_ready);
    end
    step("route_block");
  endtask

  task automatic test_indep_backpressure();
    drive(1'b1, 2'd3, 32'h11, 4'h0);
    step("indep_send");
    total++;
    if (bus.out_valid !== 4'b1010 || bus.out_data[63:32] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL indep valid/data1 got=%b/%h exp=1010/deadbeef",
               bus.out_valid, bus.out_data[63:32]);
    end
    drain_all("indep_drain");
  endtask

  task automatic test_refill();
    drive(1'b1, 2'd0, 32'hA, 4'h0);
    step("refill_a");
    drive(1'b1, 2'd0, 32'hB, 4'b0001);
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL refill in_ready got=%b exp=1", bus.in_ready);
    end
    step("refill_b");
    drive(1'b0, 2'd0, 32'h0, 4'b0001);
    step("refill_out_b");
    drain_all("refill_drain");
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 2'd2, 32'(i), 4'b0100);
      #1;
      total++;
      if (bus.in_ready !== 1'b1) begin
        bad++;
        $display("FAIL stream in_ready got=%b exp=1 word=%0d", bus.in_ready, i);
      end
      step("stream");
    end
    drain_all("stream_drain");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 2'd2, 32'hC0FFEE, 4'h0);
    step("rmid_fill");
    drive(1'b1, 2'd2, 32'h77, 4'h0);
    rst = 1'b1;
    #2;
    check_reset_outputs("reset_mid");
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'd2, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) step("rmid_idle");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15)));
      step("random");
    end
    drain_all("random_drain");
  endtask

  initial begin
    drive(1'b0, 2'd0, 32'h0, 4'h0);
    test_reset();
    test_basic_route();
    test_indep_backpressure();
    test_refill();
    test_streaming();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
